// File: rtl/lzs_pkg.sv
// Shared LZS decode-path constants and elaboration-time helpers.
package lzs_pkg;

    localparam int LZS_TOKEN_MAX_W = 13;
    localparam int LZS_WORD_W      = 64;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lzs_bit_shifter.sv
// Combinational shift-and-merge: drops consumed bits off the top of the buffer and
// inserts a freshly popped word directly below the remaining valid bits.
module lzs_bit_shifter
#(
    parameter int IN_W  = 64,
    parameter int BUF_W = 128,
    parameter int CNT_W = 8
) (
    input  logic [BUF_W-1:0] buf_cur,
    input  logic [CNT_W-1:0] consumed,
    input  logic [CNT_W-1:0] remain,
    input  logic [IN_W-1:0]  word,
    input  logic             load,
    output logic [BUF_W-1:0] buf_next
);

    logic [CNT_W-1:0] ins_shift;
    logic [BUF_W-1:0] word_ext;

    // When load is set the pop guard ensures remain <= BUF_W-IN_W, so no wrap.
    always_comb begin
        ins_shift = CNT_W'(BUF_W - IN_W) - remain;
        word_ext  = {{(BUF_W-IN_W){1'b0}}, word};
        buf_next  = (buf_cur << consumed) | (load ? (word_ext << ins_shift) : '0);
    end

endmodule

// File: rtl/lzs_bit_unpack.sv
// MSB-first bit-stream unpacker: pops words from an FWFT FIFO and presents a
// left-aligned peek window; consumer acks 1..MAX_W bits per cycle.
module lzs_bit_unpack
    import lzs_pkg::*;
#(
    parameter int IN_W  = LZS_WORD_W,
    parameter int MAX_W = LZS_TOKEN_MAX_W,
    parameter int WW    = clog2(MAX_W + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce,
    input  logic                           clr,
    input  logic                           src_empty,
    input  logic [IN_W-1:0]                fi,
    input  logic                           m_last,
    output logic                           m_src_getn,
    output logic [MAX_W-1:0]               stream_data,
    output logic                           stream_valid,
    input  logic [WW-1:0]                  stream_width,
    input  logic                           stream_ack,
    output logic [clog2(2*IN_W+1)-1:0]     bits_avail,
    output logic                           stream_done,
    output logic                           stream_err
);

    localparam int BUF_W = 2 * IN_W;
    localparam int CNT_W = clog2(BUF_W + 1);

    logic [BUF_W-1:0] buf_q;
    logic [BUF_W-1:0] buf_next;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] w_ext;
    logic [CNT_W-1:0] consumed;
    logic [CNT_W-1:0] remain;
    logic             eos_q;
    logic             eos_next;
    logic             done_q;
    logic             err_q;
    logic             acc;
    logic             bad_w;
    logic             pop;

    always_comb begin
        w_ext        = CNT_W'(stream_width);
        stream_valid = ce & ((cnt_q >= CNT_W'(MAX_W)) | (eos_q & (cnt_q != '0)));
        acc          = ce & stream_ack & stream_valid;
        bad_w        = (w_ext == '0) | (w_ext > cnt_q);
        consumed     = '0;
        if (acc) begin
            if (w_ext == '0)
                consumed = '0;
            else if (w_ext > cnt_q)
                consumed = cnt_q;
            else
                consumed = w_ext;
        end
        remain     = cnt_q - consumed;
        // Refill only when a whole word fits below what survives this cycle's consume.
        pop        = ce & ~src_empty & ~eos_q &
                     (({1'b0, remain} + (CNT_W+1)'(IN_W)) <= (CNT_W+1)'(BUF_W));
        cnt_next   = remain + (pop ? CNT_W'(IN_W) : '0);
        eos_next   = eos_q | (pop & m_last);
        m_src_getn = ~pop | rst | clr;
    end

    lzs_bit_shifter #(
        .IN_W  (IN_W),
        .BUF_W (BUF_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .buf_cur  (buf_q),
        .consumed (consumed),
        .remain   (remain),
        .word     (fi),
        .load     (pop),
        .buf_next (buf_next)
    );

    always_ff @(posedge clk) begin
        if (rst | clr) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            eos_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (ce) begin
            buf_q  <= buf_next;
            cnt_q  <= cnt_next;
            eos_q  <= eos_next;
            done_q <= eos_next & (cnt_next == '0);
            err_q  <= err_q | (acc & bad_w);
        end
    end

    assign stream_data = buf_q[BUF_W-1 -: MAX_W];
    assign bits_avail  = cnt_q;
    assign stream_done = done_q;
    assign stream_err  = err_q;

endmodule

// File: tb/tb_lzs_bit_unpack.sv
// Bench for lzs_bit_unpack: bit-queue reference model, directed scenarios, random streams.
module tb_lzs_bit_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        clr = 1'b0;
    logic        src_empty = 1'b1;
    logic [63:0] fi = '0;
    logic        m_last = 1'b0;
    logic        m_src_getn;
    logic [12:0] stream_data;
    logic        stream_valid;
    logic [3:0]  stream_width = '0;
    logic        stream_ack = 1'b0;
    logic [7:0]  bits_avail;
    logic        stream_done;
    logic        stream_err;

    int checks = 0;
    int errors = 0;
    bit gap = 1'b0;

    // Source FIFO contents and the reference model state.
    logic [63:0] src_q[$];
    bit          last_q[$];
    bit          mq[$];
    bit          m_eos = 1'b0;
    bit          m_done = 1'b0;
    bit          m_err = 1'b0;

    lzs_bit_unpack dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .clr          (clr),
        .src_empty    (src_empty),
        .fi           (fi),
        .m_last       (m_last),
        .m_src_getn   (m_src_getn),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_width (stream_width),
        .stream_ack   (stream_ack),
        .bits_avail   (bits_avail),
        .stream_done  (stream_done),
        .stream_err   (stream_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [63:0] word, input bit last);
        src_q.push_back(word);
        last_q.push_back(last);
    endtask

    // One clock: drive the FIFO head, compare against the model at negedge, advance the model.
    task automatic do_cycle();
        bit          empty_now;
        logic [63:0] word_now;
        bit          last_now;
        int          cnt;
        int          w;
        int          cons;
        bit          valid;
        bit          acc;
        bit          err_set;
        bit          pop;
        logic [12:0] win;
        empty_now = (src_q.size() == 0) || gap;
        word_now  = (src_q.size() != 0) ? src_q[0] : 64'hDEAD_BEEF_0BAD_F00D;
        last_now  = (src_q.size() != 0) ? last_q[0] : 1'b0;
        src_empty = empty_now;
        fi        = word_now;
        m_last    = last_now;
        @(negedge clk);
        cnt   = mq.size();
        valid = ce && (cnt >= 13 || (m_eos && cnt != 0));
        for (int i = 0; i < 13; i++)
            win[12-i] = (i < cnt) ? mq[i] : 1'b0;
        w       = int'(stream_width);
        acc     = ce && stream_ack && valid;
        cons    = !acc ? 0 : (w == 0 ? 0 : (w > cnt ? cnt : w));
        err_set = acc && (w == 0 || w > cnt);
        pop     = ce && !empty_now && !m_eos && (cnt - cons + 64 <= 128);
        check("stream_valid", stream_valid, valid);
        check("stream_data", stream_data, win);
        check("bits_avail", bits_avail, cnt);
        check("m_src_getn", m_src_getn, (rst || clr) ? 1'b1 : !pop);
        check("stream_done", stream_done, m_done);
        check("stream_err", stream_err, m_err);
        if (rst || clr) begin
            mq.delete();
            m_eos  = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
        end else if (ce) begin
            repeat (cons) void'(mq.pop_front());
            if (pop) begin
                for (int b = 63; b >= 0; b--)
                    mq.push_back(word_now[b]);
                void'(src_q.pop_front());
                void'(last_q.pop_front());
                if (last_now) m_eos = 1'b1;
            end
            if (err_set) m_err = 1'b1;
            m_done = m_eos && (mq.size() == 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input bit use_rst);
        src_q.delete();
        last_q.delete();
        stream_ack = 1'b0;
        if (use_rst) rst = 1'b1; else clr = 1'b1;
        do_cycle();
        rst = 1'b0;
        clr = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input bit randomize_in);
        int n;
        n = 0;
        while (!m_done && n < budget) begin
            if (randomize_in) begin
                ce           = ($urandom_range(0, 9) != 0);
                gap          = ($urandom_range(0, 5) == 0);
                stream_ack   = ($urandom_range(0, 3) != 0);
                stream_width = ($urandom_range(0, 40) == 0) ? 4'd0 : 4'($urandom_range(1, 13));
            end
            do_cycle();
            n++;
        end
        ce  = 1'b1;
        gap = 1'b0;
        if (!m_done) begin
            checks++;
            errors++;
            $error("FAIL run_to_done: observed not done after %0d cycles, expected done", budget);
        end
    endtask

    task automatic consume_59();
        stream_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            stream_width = (k == 4) ? 4'd7 : 4'd13;
            do_cycle();
        end
        stream_ack = 1'b0;
    endtask

    initial begin
        logic [63:0] tail_word;
        int          nwords;
        // Reset state
        do_cycle();
        rst = 1'b0;
        ce  = 1'b1;
        check("reset_bits", bits_avail, 8'd0);
        check("reset_valid", stream_valid, 1'b0);

        // Single word, small acks
        push_word(64'hA5C3_0000_0000_0000, 1'b1);
        do_cycle();
        check("t1_bits64", bits_avail, 8'd64);
        check("t1_nib_a", stream_data[12:9], 4'hA);
        stream_ack = 1'b1;
        stream_width = 4'd4;
        do_cycle();
        check("t1_bits60", bits_avail, 8'd60);
        check("t1_nib_5", stream_data[12:9], 4'h5);
        do_cycle();
        check("t1_bits56", bits_avail, 8'd56);
        check("t1_byte_c3", stream_data[12:5], 8'hC3);
        stream_width = 4'd8;
        do_cycle();
        check("t1_bits48", bits_avail, 8'd48);
        restart(1'b0);

        // Back-to-back 13-bit tokens across word boundaries
        for (int i = 0; i < 8; i++) push_word(64'h0123_4567_89AB_CDEF, i == 7);
        stream_ack = 1'b1;
        stream_width = 4'd13;
        do_cycle();
        check("t2_tok0", stream_data, 13'h0024);
        do_cycle();
        check("t2_tok1", stream_data, 13'h0D15);
        run_to_done(200, 1'b0);
        restart(1'b0);

        // Tail of 5 bits consumed exactly
        tail_word = {$urandom(), $urandom()};
        tail_word[4:0] = 5'b10110;
        push_word(tail_word, 1'b1);
        do_cycle();
        consume_59();
        check("t3_bits5", bits_avail, 8'd5);
        check("t3_valid", stream_valid, 1'b1);
        check("t3_data", stream_data, 13'h1600);
        stream_ack = 1'b1;
        stream_width = 4'd5;
        do_cycle();
        stream_ack = 1'b0;
        check("t3_bits0", bits_avail, 8'd0);
        check("t3_nvalid", stream_valid, 1'b0);
        check("t3_done", stream_done, 1'b1);
        repeat (3) do_cycle();
        check("t3_done_held", stream_done, 1'b1);
        restart(1'b0);

        // Over-consume at tail, then zero-width ack mid-stream
        push_word(tail_word, 1'b1);
        do_cycle();
        consume_59();
        stream_ack = 1'b1;
        stream_width = 4'd9;
        do_cycle();
        stream_ack = 1'b0;
        check("t4_err", stream_err, 1'b1);
        check("t4_bits0", bits_avail, 8'd0);
        check("t4_done", stream_done, 1'b1);
        restart(1'b0);
        check("t4_err_cleared", stream_err, 1'b0);
        push_word({$urandom(), $urandom()}, 1'b0);
        do_cycle();
        stream_ack = 1'b1;
        stream_width = 4'd13;
        do_cycle();
        stream_width = 4'd0;
        do_cycle();
        stream_ack = 1'b0;
        check("t4_zero_err", stream_err, 1'b1);
        check("t4_zero_bits", bits_avail, 8'd51);
        restart(1'b0);

        // Clock-enable freeze with acks and data pending
        for (int i = 0; i < 6; i++) push_word({$urandom(), $urandom()}, i == 5);
        stream_ack = 1'b1;
        stream_width = 4'd11;
        repeat (3) do_cycle();
        ce = 1'b0;
        repeat (10) do_cycle();
        ce = 1'b1;
        run_to_done(200, 1'b0);
        restart(1'b0);

        // clr, then rst, while a pop is pending; fresh stream afterwards
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) push_word({$urandom(), $urandom()}, 1'b0);
            stream_ack = 1'b1;
            stream_width = 4'd13;
            repeat (4) do_cycle();
            restart(r == 1);
            check("t6_bits0", bits_avail, 8'd0);
            check("t6_err0", stream_err, 1'b0);
            check("t6_done0", stream_done, 1'b0);
            for (int i = 0; i < 3; i++) push_word({$urandom(), $urandom()}, i == 2);
            stream_ack = 1'b1;
            stream_width = 4'd13;
            run_to_done(200, 1'b0);
        end
        restart(1'b1);

        // Random streams: random widths, acks, gaps and clock enable
        for (int s = 0; s < 30; s++) begin
            nwords = $urandom_range(1, 6);
            for (int i = 0; i < nwords; i++) push_word({$urandom(), $urandom()}, i == nwords - 1);
            run_to_done(3000, 1'b1);
            repeat (2) do_cycle();
            restart(s % 5 == 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
